// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line rate, clock rate, bit-period math, FSM state encodings.
// Latency: n/a (compile-time constants and a pure function only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int unsigned DEF_BAUDRATE = 115200;
    localparam int unsigned DEF_FREQ     = 50_000_000;

    // Whole clocks per serial bit; the truncation is accepted, because
    // sampling at bit centres leaves ample margin for the rounding error.
    function automatic int unsigned bit_period(input int unsigned freq,
                                               input int unsigned baud);
        return freq / baud;
    endfunction

    function automatic int unsigned half_period(input int unsigned freq,
                                                input int unsigned baud);
        return bit_period(freq, baud) / 2;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; resets to 1 (idle line level).
// Latency: 2 clocks from d_i to q_o.
// Backpressure: none, free-running.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, timing from the detected start edge.
// Latency: VALID/FRAME_ERR pulse 3 + H + 9T clocks after RX falls (2 sync + 1 edge + centres).
// Backpressure: none; RDATA is held until the next good frame, and overrun is not detected.
//   CLOCK_50M : system clock, rising edge
//   RESET_N   : asynchronous active-low reset
//   RX        : serial line, idle high, LSB first
//   RDATA     : last good byte
//   VALID     : 1-clock pulse, RDATA updated
//   FRAME_ERR : 1-clock pulse, stop bit low and byte dropped
//   IDLE      : no frame in progress
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUDRATE = DEF_BAUDRATE,
    parameter int unsigned FREQ     = DEF_FREQ
) (
    input  logic       CLOCK_50M,
    input  logic       RESET_N,
    input  logic       RX,
    output logic [7:0] RDATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       IDLE
);

    localparam int unsigned T      = bit_period(FREQ, BAUDRATE);
    localparam int unsigned H      = half_period(FREQ, BAUDRATE);
    localparam logic [31:0] T_LAST = 32'(T - 1);
    localparam logic [31:0] H_LAST = 32'(H - 1);

    logic        rx_s;       // synchronized line
    logic        rx_prev_q;  // rx_s one clock earlier, for edge detection
    uart_state_e state_q;
    logic [31:0] cnt_clk_q;
    logic [2:0]  cnt_bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  rdata_q;
    logic        valid_q;
    logic        ferr_q;

    sync_2ff u_sync (
        .clk_i  (CLOCK_50M),
        .rst_ni (RESET_N),
        .d_i    (RX),
        .q_o    (rx_s)
    );

    always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_clk_q <= '0;
            cnt_bit_q <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                // Only a real high-to-low transition starts a frame, so a line
                // stuck low after a framing error cannot retrigger.
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q   <= ST_START;
                        cnt_clk_q <= '0;
                    end
                end
                // Re-check the line at mid start bit; high means it was a glitch.
                ST_START: begin
                    if (cnt_clk_q == H_LAST) begin
                        cnt_clk_q <= '0;
                        cnt_bit_q <= '0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_clk_q <= cnt_clk_q + 32'd1;
                    end
                end
                // Already at a bit centre, so one full period lands on the next centre.
                ST_DATA: begin
                    if (cnt_clk_q == T_LAST) begin
                        cnt_clk_q          <= '0;
                        shift_q[cnt_bit_q] <= rx_s;
                        cnt_bit_q          <= cnt_bit_q + 3'd1;
                        if (cnt_bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_clk_q <= cnt_clk_q + 32'd1;
                    end
                end
                // Go idle at stop-bit centre: a new start edge can follow at once.
                ST_STOP: begin
                    if (cnt_clk_q == T_LAST) begin
                        cnt_clk_q <= '0;
                        state_q   <= ST_IDLE;
                        if (rx_s) begin
                            rdata_q <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end else begin
                        cnt_clk_q <= cnt_clk_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign RDATA     = rdata_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign IDLE      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus random frames against a frame-level reference: the expected outcome
// of a frame is decided by its stop bit. Its time comes from the falling edge plus
// the fixed receive latency.
module tb_uart_rx;

    localparam int T   = 50_000_000 / 115200;   // 434 clocks per bit
    localparam int H   = T / 2;                 // 217
    localparam int LAT = 2 + H + 9 * T + 1;     // RX fall -> pulse, in clocks

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] RDATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       IDLE;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];
    logic       prev_v = 1'b0;
    logic       prev_e = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    uart_rx dut (
        .CLOCK_50M (clk),
        .RESET_N   (rst_n),
        .RX        (rx),
        .RDATA     (RDATA),
        .VALID     (VALID),
        .FRAME_ERR (FRAME_ERR),
        .IDLE      (IDLE)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every pulse and checks exclusivity and one-clock width.
    always @(negedge clk) begin
        if (VALID === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(RDATA);
        end
        if (FRAME_ERR === 1'b1) e_cyc.push_back(cyc);
        if (VALID === 1'b1 || FRAME_ERR === 1'b1) begin
            n_assert++;
            assert (!(VALID && FRAME_ERR)) else begin
                n_fail++;
                $error("FAIL pulse_excl observed valid=%0b frame_err=%0b required not both", VALID, FRAME_ERR);
            end
            n_assert++;
            assert (!(VALID && prev_v) && !(FRAME_ERR && prev_e)) else begin
                n_fail++;
                $error("FAIL pulse_width observed valid=%0b/%0b err=%0b/%0b required single clock",
                       prev_v, VALID, prev_e, FRAME_ERR);
            end
        end
        prev_v = VALID;
        prev_e = FRAME_ERR;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog observed simulation still running required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drives one 8N1 frame; caller must be at a negedge. pct scales the bit period
    // (100 = nominal). abort_at >= 0 stops driving after that many clocks.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int pct,
                              input int abort_at, output int fall);
        logic [9:0] bits;
        int e;
        int idx;
        bits = {stop, data, 1'b0};
        fall = cyc;
        e    = 0;
        idx  = 0;
        while (idx < 10 && e != abort_at) begin
            rx = bits[idx];
            @(negedge clk);
            e++;
            idx = (e * 100) / (T * pct);
        end
        if (e != abort_at) rx = 1'b1;
    endtask

    task automatic clear_q();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    task automatic check_good(input string tag, input int fall, input logic [7:0] data);
        wait_to(fall + LAT + 2);
        chk({tag, "_nvalid"}, v_cyc.size(), 1);
        chk({tag, "_nerr"}, e_cyc.size(), 0);
        if (v_cyc.size() > 0) begin
            chk({tag, "_data"}, v_dat[0], data);
            chk({tag, "_lat"}, v_cyc[0] - fall, LAT);
        end
        chk({tag, "_idle"}, IDLE, 1);
        model_rdata = data;
        chk({tag, "_held"}, RDATA, model_rdata);
        clear_q();
    endtask

    initial begin
        int f;
        int f2;
        logic [7:0] b;
        int p;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", RDATA, 8'h00);
        chk("rst_valid", VALID, 0);
        chk("rst_ferr", FRAME_ERR, 0);
        chk("rst_idle", IDLE, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte
        send_frame(8'h41, 1'b1, 100, -1, f);
        check_good("b41", f, 8'h41);

        // Back-to-back frames with no gap
        send_frame(8'h55, 1'b1, 100, -1, f);
        send_frame(8'hAA, 1'b1, 100, -1, f2);
        wait_to(f2 + LAT + 2);
        chk("b2b_nvalid", v_cyc.size(), 2);
        chk("b2b_nerr", e_cyc.size(), 0);
        if (v_cyc.size() == 2) begin
            chk("b2b_d0", v_dat[0], 8'h55);
            chk("b2b_d1", v_dat[1], 8'hAA);
            chk("b2b_lat0", v_cyc[0] - f, LAT);
            chk("b2b_gap", v_cyc[1] - v_cyc[0], 10 * T);
        end
        model_rdata = 8'hAA;
        clear_q();

        // 100-clock glitch while idle
        repeat (20) @(negedge clk);
        f = cyc;
        rx = 1'b0;
        wait_to(f + 50);
        chk("glitch_busy", IDLE, 0);
        wait_to(f + 100);
        rx = 1'b1;
        wait_to(f + H + 3);
        chk("glitch_idle", IDLE, 1);
        wait_to(f + 2 * T);
        chk("glitch_nvalid", v_cyc.size(), 0);
        chk("glitch_nerr", e_cyc.size(), 0);
        chk("glitch_rdata", RDATA, model_rdata);
        clear_q();

        // Stop bit forced low
        send_frame(8'h3C, 1'b0, 100, -1, f);
        wait_to(f + LAT + 2);
        chk("ferr_nerr", e_cyc.size(), 1);
        chk("ferr_nvalid", v_cyc.size(), 0);
        if (e_cyc.size() > 0) chk("ferr_lat", e_cyc[0] - f, LAT);
        chk("ferr_rdata", RDATA, model_rdata);
        chk("ferr_idle", IDLE, 1);
        clear_q();
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xF0
        send_frame(8'hF0, 1'b1, 100, 5 * T + T / 2, f);
        chk("mid_busy", IDLE, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", RDATA, 8'h00);
        chk("mid_rst_valid", VALID, 0);
        chk("mid_rst_ferr", FRAME_ERR, 0);
        chk("mid_rst_idle", IDLE, 1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 8'h00;
        f = cyc;
        wait_to(f + 6 * T);
        chk("mid_nvalid", v_cyc.size(), 0);
        chk("mid_nerr", e_cyc.size(), 0);
        clear_q();
        send_frame(8'h0F, 1'b1, 100, -1, f);
        check_good("after_rst", f, 8'h0F);

        // Baud skew at the stimulus
        send_frame(8'h00, 1'b1, 102, -1, f);
        check_good("skew_slow", f, 8'h00);
        repeat (10) @(negedge clk);
        send_frame(8'hFF, 1'b1, 98, -1, f);
        check_good("skew_fast", f, 8'hFF);

        // Random bytes at random skew within +-2%
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(30, 1)) @(negedge clk);
            b = 8'($urandom);
            p = int'($urandom_range(102, 98));
            send_frame(b, 1'b1, p, -1, f);
            check_good("rand", f, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
